tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receiver/demultiplexer for the serial, time-interleaved 2-channel stream produced by the team's 2:1 select mux path.
- Each accepted bit is steered by `sel` to channel 0 or 1, MSB first, and shifted into that channel's WIDTH-bit word.
- Each completed word is placed in a per-channel holding register and offered downstream with a valid/ready handshake.
- Sits at the far end of the mux link, feeding per-channel consumers.

Parameters:
- WIDTH, 8, data bits per channel word (legal range 2..32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  1  serial data bit.
- sel  input  1  channel select for `din`: 0 = channel 0, 1 = channel 1.
- din_valid  input  1  `din`/`sel` qualify this cycle.
- din_ready  output  1  block can accept the offered bit.
- dout_0  output  WIDTH  channel 0 assembled word.
- dout_0_valid  output  1  `dout_0` holds an unconsumed word.
- dout_0_ready  input  1  downstream consumes `dout_0`.
- dout_1  output  WIDTH  channel 1 assembled word.
- dout_1_valid  output  1  `dout_1` holds an unconsumed word.
- dout_1_ready  input  1  downstream consumes `dout_1`.
- par_err_0  output  1  parity error on the current `dout_0` word (optional feature).
- par_err_1  output  1  parity error on the current `dout_1` word (optional feature).

Behaviour:
- Reset:
  - Applies only on a clk edge with rst=1.
  - Clears all shift registers, bit counters, holding registers, valid and parity-error flags.
  - After reset: dout_x=0, dout_x_valid=0, par_err_x=0.
  - din_ready reflects reset state combinationally, so it reads 1.
  - Reset mid-word discards partial words in both channels.
  - Reset mid-handshake drops any pending word.
- Per-channel state, c in {0,1}:
  - shift register sr_c, WIDTH-1 bits.
  - counter cnt_c, range 0..WIDTH-1.
  - holding register dout_c and flag dout_c_valid.
  - The two channels are fully independent; `sel` may change every cycle.
- Accept:
  - A bit is accepted when din_valid && din_ready. Let c = sel.
  - If cnt_c < WIDTH-1: sr_c <= {sr_c, din} (MSB first) and cnt_c <= cnt_c+1.
  - If cnt_c == WIDTH-1 (last bit): dout_c <= {sr_c, din}, dout_c_valid <= 1, cnt_c <= 0.
  - Latency: the word is visible the cycle after its last bit is accepted.
- din_ready (combinational):
  - Equals 0 only when cnt_sel == WIDTH-1 and dout_sel_valid == 1 and dout_sel_ready == 0.
  - That is, the last bit is stalled only while the addressed holding register is full and not draining.
  - Non-final bits are always accepted.
  - din_ready depends on `sel` even when din_valid=0.
- Output handshake:
  - dout_c_valid && dout_c_ready consumes the word, and dout_c_valid clears next cycle.
  - Simultaneous consume and load on the same channel: the load wins; dout_c_valid stays 1 and dout_c takes the new word (no bubble).
  - dout_c is stable while dout_c_valid=1 and it is not consumed.
- Other rules:
  - dout_c_ready with dout_c_valid=0 is ignored.
  - din_valid=0 freezes all input-side state.
- Counters wrap to 0 after each word; there is no frame alignment beyond reset.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - Each channel word is WIDTH+1 serial bits: WIDTH data bits, MSB first, followed by one even-parity bit.
  - cnt_c ranges 0..WIDTH.
  - On the parity bit, dout_c loads the data and par_err_c <= (^data) ^ parity_bit.
  - par_err_c is held with the word and updates only on a load.
  - The stall rule applies to the parity bit, i.e. the final bit of the word.
- When not defined:
  - Words are WIDTH bits.
  - par_err_0 and par_err_1 are tied to constant 0; the ports remain present.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> all dout=0, valids=0, din_ready=1.
2. Channel 0 word, WIDTH=8: bits 1,0,1,0,0,1,0,1 with sel=0 and dout_0_ready=1 -> dout_0=8'hA5, dout_0_valid=1 for one cycle, one cycle after the 8th bit.
3. Interleave: alternate sel each cycle, ch0 word 0x3C, ch1 word 0xF0 -> both valid in consecutive cycles with correct values; no cross-channel corruption.
4. Backpressure: dout_1_ready=0, hold word 0x11, then send 8 bits of 0x22 on ch1:
   - din_ready drops at the 8th bit.
   - Raise dout_1_ready -> 0x11 is consumed and 0x22 loads the same cycle; dout_1_valid stays 1.
5. Reset mid-word: 4 bits into ch0, assert rst -> next full 8 bits form a correct fresh word; no stale bits.
6. With TDM_DEMUX_PARITY_EN:
   - 0xA5 followed by parity 0 -> par_err_0=0.
   - 0xA5 followed by parity 1 -> par_err_0=1.

Source files
------------

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//
// Receiver for a serial, time-interleaved 2-channel bit stream. Each accepted
// bit is steered by `sel` to channel 0 or 1 and shifted MSB first into that
// channel's word. A completed word is moved into a per-channel holding
// register and offered downstream with a valid/ready handshake.
//
// Handshake semantics (all interfaces): a transfer happens on a rising clk
// edge where valid && ready are both 1. The source holds its payload stable
// while valid=1 and ready=0. Here the upstream side may only be stalled on
// the final bit of a word, when the addressed holding register is still full
// and is not being drained in the same cycle.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN
//   Defined   : each word is WIDTH data bits followed by one even-parity bit;
//               par_err_c flags a parity mismatch and is held with the word.
//   Undefined : words are WIDTH bits; par_err_0/par_err_1 are constant 0.
//
// Parameters:
//   WIDTH         data bits per channel word (2..32)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   din           serial data bit
//   sel           channel select for din (0 = ch0, 1 = ch1)
//   din_valid     din/sel qualify this cycle
//   din_ready     block can accept the offered bit (combinational, depends on sel)
//   dout_0        channel 0 assembled word
//   dout_0_valid  dout_0 holds an unconsumed word
//   dout_0_ready  downstream consumes dout_0
//   dout_1        channel 1 assembled word
//   dout_1_valid  dout_1 holds an unconsumed word
//   dout_1_ready  downstream consumes dout_1
//   par_err_0     parity error on the current dout_0 word
//   par_err_1     parity error on the current dout_1 word
// -----------------------------------------------------------------------------
module tdm_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout_0,
    output logic             dout_0_valid,
    input  logic             dout_0_ready,
    output logic [WIDTH-1:0] dout_1,
    output logic             dout_1_valid,
    input  logic             dout_1_ready,
    output logic             par_err_0,
    output logic             par_err_1
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NB = WIDTH + 1;   // serial bits per word incl. parity
`else
    localparam int NB = WIDTH;
`endif
    // Bits held before the final bit arrives.
    localparam int SRW = NB - 1;
    localparam int CW  = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [1:0][SRW-1:0]   sr;
    logic [1:0][CW-1:0]    cnt;
    logic [1:0][WIDTH-1:0] hold;
    logic [1:0]            hold_valid;
    logic [1:0]            hold_ready;
    logic                  accept;

    assign hold_ready = {dout_1_ready, dout_0_ready};

    // Only the final bit of a word can be stalled; draining in the same cycle
    // frees the holding register, so it does not stall.
    assign din_ready = !((cnt[sel] == LAST) && hold_valid[sel] && !hold_ready[sel]);
    assign accept    = din_valid && din_ready;

`ifdef TDM_DEMUX_PARITY_EN
    logic [1:0] perr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_valid <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            perr       <= '0;
`endif
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (accept && (sel == 1'(c)) && (cnt[c] == LAST)) begin
                    // Load wins over a simultaneous consume: no bubble.
`ifdef TDM_DEMUX_PARITY_EN
                    hold[c] <= sr[c];
                    perr[c] <= (^sr[c]) ^ din;
`else
                    hold[c] <= {sr[c], din};
`endif
                    hold_valid[c] <= 1'b1;
                    cnt[c]        <= '0;
                end else begin
                    if (accept && (sel == 1'(c))) begin
                        // Cast keeps the low SRW bits, i.e. shift left by one.
                        sr[c]  <= SRW'({sr[c], din});
                        cnt[c] <= cnt[c] + 1'b1;
                    end
                    if (hold_ready[c]) begin
                        hold_valid[c] <= 1'b0;
                    end
                end
            end
        end
    end

    assign dout_0       = hold[0];
    assign dout_1       = hold[1];
    assign dout_0_valid = hold_valid[0];
    assign dout_1_valid = hold_valid[1];

`ifdef TDM_DEMUX_PARITY_EN
    assign par_err_0 = perr[0];
    assign par_err_1 = perr[1];
`else
    assign par_err_0 = 1'b0;
    assign par_err_1 = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         din, sel, din_valid;
  logic         din_ready;
  logic [W-1:0] dout_0, dout_1;
  logic         dout_0_valid, dout_1_valid;
  logic         dout_0_ready, dout_1_ready;
  logic         par_err_0, par_err_1;

  int checks = 0;
  int errors = 0;

  // expected {par_err, data} per channel
  logic [W:0] exp0_q[$];
  logic [W:0] exp1_q[$];

  tdm_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .din_valid(din_valid),
    .din_ready(din_ready),
    .dout_0(dout_0), .dout_0_valid(dout_0_valid), .dout_0_ready(dout_0_ready),
    .dout_1(dout_1), .dout_1_valid(dout_1_valid), .dout_1_ready(dout_1_ready),
    .par_err_0(par_err_0), .par_err_1(par_err_1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard: compare whenever a word is consumed downstream
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_0_valid && dout_0_ready) begin
        if (exp0_q.size() == 0) chk("ch0_unexpected_word", {23'd0, par_err_0, dout_0}, 32'h1_0000);
        else chk("ch0_word", {23'd0, par_err_0, dout_0}, {23'd0, exp0_q.pop_front()});
      end
      if (dout_1_valid && dout_1_ready) begin
        if (exp1_q.size() == 0) chk("ch1_unexpected_word", {23'd0, par_err_1, dout_1}, 32'h1_0000);
        else chk("ch1_word", {23'd0, par_err_1, dout_1}, {23'd0, exp1_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic b, input logic s);
    int n;
    din = b; sel = s; din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_bit_timeout", {31'd0, din_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [W:0] exp_word(input logic [W-1:0] d, input logic flip);
`ifdef TDM_DEMUX_PARITY_EN
    return {flip, d};
`else
    return {1'b0, d};
`endif
  endfunction

  // Sends one full word; flip=1 inverts the parity bit when parity is enabled.
  task automatic send_word(input logic ch, input logic [W-1:0] d, input logic flip);
    if (ch) exp1_q.push_back(exp_word(d, flip));
    else    exp0_q.push_back(exp_word(d, flip));
    for (int i = W - 1; i >= 0; i--) send_bit(d[i], ch);
`ifdef TDM_DEMUX_PARITY_EN
    send_bit((^d) ^ flip, ch);
`endif
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         lastb;
    rst = 1'b1; din = 1'b0; sel = 1'b0; din_valid = 1'b0;
    dout_0_ready = 1'b1; dout_1_ready = 1'b1;

    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dout_0", {24'd0, dout_0}, 32'd0);
    chk("rst_dout_1", {24'd0, dout_1}, 32'd0);
    chk("rst_valids", {30'd0, dout_1_valid, dout_0_valid}, 32'd0);
    chk("rst_par_err", {30'd0, par_err_1, par_err_0}, 32'd0);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd1);

    // 2. channel 0 word A5, valid for exactly one cycle
    send_word(1'b0, 8'hA5, 1'b0);
    din_valid = 1'b0;
    chk("t2_valid_after_last", {31'd0, dout_0_valid}, 32'd1);
    @(posedge clk); #1;
    chk("t2_valid_one_cycle", {31'd0, dout_0_valid}, 32'd0);

    // 3. interleave ch0=3C, ch1=F0
    a = 8'h3C; b = 8'hF0;
    exp0_q.push_back(exp_word(a, 1'b0));
    exp1_q.push_back(exp_word(b, 1'b0));
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(a[i], 1'b0);
      if (i == 0) begin
`ifdef TDM_DEMUX_PARITY_EN
        send_bit(b[i], 1'b1);
        send_bit(^a, 1'b0);
        chk("t3_ch0_valid", {31'd0, dout_0_valid}, 32'd1);
        send_bit(^b, 1'b1);
`else
        chk("t3_ch0_valid", {31'd0, dout_0_valid}, 32'd1);
        send_bit(b[i], 1'b1);
`endif
      end else begin
        send_bit(b[i], 1'b1);
      end
    end
    din_valid = 1'b0;
    chk("t3_ch1_valid", {31'd0, dout_1_valid}, 32'd1);
    @(posedge clk); #1;

    // 4. backpressure on ch1
    dout_1_ready = 1'b0;
    send_word(1'b1, 8'h11, 1'b0);
    din_valid = 1'b0;
    chk("t4_hold_valid", {31'd0, dout_1_valid}, 32'd1);
    b = 8'h22;
    exp1_q.push_back(exp_word(b, 1'b0));
`ifdef TDM_DEMUX_PARITY_EN
    for (int i = W - 1; i >= 0; i--) send_bit(b[i], 1'b1);
    lastb = ^b;
`else
    for (int i = W - 1; i >= 1; i--) send_bit(b[i], 1'b1);
    lastb = b[0];
`endif
    din = lastb; sel = 1'b1; din_valid = 1'b1;
    #1;
    chk("t4_stall_last_bit", {31'd0, din_ready}, 32'd0);
    sel = 1'b0;
    #1;
    chk("t4_ready_follows_sel", {31'd0, din_ready}, 32'd1);
    sel = 1'b1;
    @(posedge clk); #1;
    chk("t4_still_stalled", {31'd0, din_ready}, 32'd0);
    chk("t4_word_stable", {24'd0, dout_1}, 32'h11);
    dout_1_ready = 1'b1;
    #1;
    chk("t4_ready_on_drain", {31'd0, din_ready}, 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("t4_no_bubble", {31'd0, dout_1_valid}, 32'd1);
    chk("t4_new_word", {24'd0, dout_1}, 32'h22);
    @(posedge clk); #1;
    chk("t4_drained", {31'd0, dout_1_valid}, 32'd0);

    // 5. reset mid-word discards partial bits
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_valid_cleared", {30'd0, dout_1_valid, dout_0_valid}, 32'd0);
    chk("t5_din_ready", {31'd0, din_ready}, 32'd1);
    send_word(1'b0, 8'h5A, 1'b0);
    din_valid = 1'b0;
    @(posedge clk); #1;

    // 6. parity good / bad (expected error is 0 when parity is disabled)
    send_word(1'b0, 8'hA5, 1'b0);
    send_word(1'b0, 8'hA5, 1'b1);
    send_word(1'b1, 8'h01, 1'b1);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("exp0_q_empty", exp0_q.size(), 32'd0);
    chk("exp1_q_empty", exp1_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
